// File: rtl/otter_io_timer.sv
// Memory-mapped down-counting timer for the OTTER I/O bus with prescaler, auto-reload and level IRQ.
// Optional expiry counter at offset 0x10 is built only when OTTER_TIMER_OVF_CNT_EN is defined.
module otter_io_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int unsigned PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] iobus_in,
    output logic        intr
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    state_t      state, state_n;
    logic [2:0]  ctrl, ctrl_n;
    logic [31:0] load, load_n;
    logic [31:0] count, count_n;
    logic        exp_flag, exp_n;
    logic [15:0] presc, presc_n;
    logic        expire;
    logic [31:0] ovf_rd;
    logic [31:0] rdata;

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_load, wr_count, wr_status;
    logic       unused_addr_bits;

    assign hit              = (iobus_addr[31:5] == BASE_ADDR[31:5]);
    assign off              = iobus_addr[4:2];
    assign unused_addr_bits = ^iobus_addr[1:0];
    assign wr_ctrl          = iobus_wr && hit && (off == 3'd0);
    assign wr_load          = iobus_wr && hit && (off == 3'd1);
    assign wr_count         = iobus_wr && hit && (off == 3'd2);
    assign wr_status        = iobus_wr && hit && (off == 3'd3);

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ctrl     <= '0;
            load     <= '0;
            count    <= '0;
            exp_flag <= 1'b0;
            presc    <= '0;
        end else begin
            state    <= state_n;
            ctrl     <= ctrl_n;
            load     <= load_n;
            count    <= count_n;
            exp_flag <= exp_n;
            presc    <= presc_n;
        end
    end

    // Bus writes are applied after tick handling so a same-edge COUNT write beats
    // the decrement/reload; a CTRL write restarts or stops the run and absorbs the tick.
    always_comb begin
        state_n = state;
        ctrl_n  = ctrl;
        load_n  = load;
        count_n = count;
        exp_n   = exp_flag;
        presc_n = '0;
        expire  = 1'b0;

        if (state == RUN && !wr_ctrl) begin
            if (presc == PRE_LAST) begin
                if (count != '0) begin
                    count_n = count - 32'd1;
                end else begin
                    expire = 1'b1;
                    if (ctrl[1]) begin
                        count_n = load;
                    end else begin
                        ctrl_n[0] = 1'b0;
                        state_n   = DONE;
                    end
                end
            end else begin
                presc_n = presc + 16'd1;
            end
        end

        if (wr_ctrl) begin
            ctrl_n = iobus_out[2:0];
            if (iobus_out[0]) begin
                state_n = RUN;
                count_n = load;
            end else if (state == RUN) begin
                state_n = IDLE;
            end
        end
        if (wr_load)
            load_n = iobus_out;
        if (wr_count)
            count_n = iobus_out;
        if (wr_status && iobus_out[0])
            exp_n = 1'b0;
        if (expire)
            exp_n = 1'b1;
    end

`ifdef OTTER_TIMER_OVF_CNT_EN
    logic [7:0] ovf, ovf_n;
    logic       wr_ovf;

    assign wr_ovf = iobus_wr && hit && (off == 3'd4);

    always_comb begin
        ovf_n = ovf;
        if (expire && ovf != 8'hFF)
            ovf_n = ovf + 8'd1;
        if (wr_ovf)
            ovf_n = {7'd0, expire};
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST)
            ovf <= '0;
        else
            ovf <= ovf_n;
    end

    assign ovf_rd = {24'd0, ovf};
`else
    assign ovf_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                3'd0:    rdata = {29'd0, ctrl};
                3'd1:    rdata = load;
                3'd2:    rdata = count;
                3'd3:    rdata = {31'd0, exp_flag};
                3'd4:    rdata = ovf_rd;
                default: rdata = '0;
            endcase
        end
    end

    assign iobus_in = rdata;
    assign intr     = exp_flag & ctrl[2];

endmodule

// File: tb/tb_otter_io_timer.sv
// Self-checking bench for otter_io_timer: directed timing checks plus randomized bus traffic
// compared against a behavioural model of the timer rules.
module tb_otter_io_timer;

    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam int unsigned PRE  = 4;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] iobus_addr = '0;
    logic [31:0] iobus_out  = '0;
    logic        iobus_wr   = 1'b0;
    logic [31:0] iobus_in;
    logic        intr;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    otter_io_timer #(
        .BASE_ADDR(BASE),
        .PRESCALE (PRE)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .iobus_addr(iobus_addr),
        .iobus_out (iobus_out),
        .iobus_wr  (iobus_wr),
        .iobus_in  (iobus_in),
        .intr      (intr)
    );

    // Reference model: architectural registers plus cycles elapsed in the current tick period
    bit          m_run, m_auto, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    int unsigned m_since, m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_auto = 0; m_ie = 0; m_exp = 0;
        m_load = '0; m_count = '0; m_since = 0; m_ovf = 0;
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_window(a)) return '0;
        case ((a >> 2) & 32'd7)
            32'd0:   return {29'd0, m_ie, m_auto, m_run};
            32'd1:   return m_load;
            32'd2:   return m_count;
            32'd3:   return {31'd0, m_exp};
`ifdef OTTER_TIMER_OVF_CNT_EN
            32'd4:   return 32'(m_ovf);
`endif
            default: return '0;
        endcase
    endfunction

    task automatic model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit          w;
        bit          expire;
        logic [31:0] off;
        logic [31:0] cnt;
        w      = wr && in_window(a);
        off    = (a >> 2) & 32'd7;
        expire = 0;
        cnt    = m_count;
        if (m_run && !(w && off == 0)) begin
            if (m_since == PRE - 1) begin
                m_since = 0;
                if (m_count == 0) begin
                    expire = 1;
                    if (m_auto) cnt = m_load;
                    else        m_run = 0;
                end else begin
                    cnt = m_count - 1;
                end
            end else begin
                m_since++;
            end
        end
        if (w) begin
            case (off)
                32'd0: begin
                    m_run = d[0]; m_auto = d[1]; m_ie = d[2]; m_since = 0;
                    if (d[0]) cnt = m_load;
                end
                32'd1: m_load = d;
                32'd2: cnt = d;
                32'd3: if (d[0]) m_exp = 0;
                32'd4: m_ovf = 0;
                default: ;
            endcase
        end
        if (expire) begin
            m_exp = 1;
            m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
        end
        m_count = cnt;
    endtask

    task automatic cyc(input bit wr, input logic [31:0] a, input logic [31:0] d);
        iobus_wr   = wr;
        iobus_addr = a;
        iobus_out  = d;
        @(posedge clk);
        model_edge(wr, a, d);
        #1;
        check("intr", 32'(intr), 32'(m_exp & m_ie));
        @(negedge clk);
        iobus_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, BASE, '0);
    endtask

    task automatic wreg(input logic [31:0] off, input logic [31:0] d);
        cyc(1'b1, BASE + off, d);
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        iobus_addr = a;
        iobus_wr   = 1'b0;
        #1;
        check(tag, iobus_in, model_read(a));
    endtask

    task automatic rdc(input logic [31:0] a, input string tag, input logic [31:0] want);
        iobus_addr = a;
        iobus_wr   = 1'b0;
        #1;
        check(tag, iobus_in, want);
    endtask

    task automatic rd_all(input string tag);
        for (int unsigned k = 0; k < 5; k++) rd(BASE + 32'(4 * k), tag);
    endtask

    task automatic wait_intr(input int max, output int n);
        n = 0;
        while (!intr && n <= max) begin
            cyc(1'b0, BASE, '0);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r;
        logic [31:0] off;
        logic [31:0] d;
        logic [31:0] a;

        model_reset();
        repeat (3) @(negedge clk);
        for (int unsigned k = 0; k < 5; k++) rdc(BASE + 32'(4 * k), "reset_reg", '0);
        check("reset_intr", 32'(intr), 0);
        RST = 1'b1;
        @(negedge clk);

        // One-shot: LOAD=3, EN|IE -> expiry 16 clk after the CTRL edge, then stopped
        wreg(32'h4, 3);
        wreg(32'h0, 5);
        wait_intr(40, n);
        check("oneshot_latency", n, 16);
        rdc(BASE, "oneshot_ctrl", 4);
        rdc(BASE + 8, "oneshot_count", 0);
        idle(10);
        rdc(BASE + 8, "done_count_held", 0);
        rd_all("oneshot_model");

        // Auto-reload: LOAD=2 -> 12 clk period; W1C drops intr; W1C on expiry edge loses
        wreg(32'hC, 1);
        wreg(32'h4, 2);
        wreg(32'h0, 7);
        wait_intr(40, n);
        check("auto_first", n, 12);
        wreg(32'hC, 1);
        check("w1c_drop", 32'(intr), 0);
        wait_intr(40, n);
        check("auto_period", n + 1, 12);
        wreg(32'hC, 1);
        idle(10);
        wreg(32'hC, 1);
        check("w1c_vs_set", 32'(intr), 1);

        // Bus decode
        wreg(32'h0, 0);
        cyc(1'b1, BASE + 32'h24, 32'hFFFF);
        cyc(1'b1, BASE - 32'h4, 32'hFFFF);
        rdc(BASE + 4, "decode_load", 2);
        rdc(BASE, "decode_ctrl", 0);
        rd_all("decode_model");
        idle(1);
        rdc(BASE + 32'h1C, "rd_off7", 0);
        rdc(32'h1100_0000, "rd_outside", 0);
        rdc(BASE + 32'h17, "rd_off5_unaligned", 0);

        // Stop/restart
        wreg(32'hC, 1);
        wreg(32'h4, 9);
        wreg(32'h0, 1);
        idle(1);
        wreg(32'h8, 5);
        wreg(32'h0, 0);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            rdc(BASE + 8, "stop_count_held", 5);
        end
        wreg(32'h0, 1);
        rdc(BASE + 8, "restart_reload", 9);

        // Expiry counter
`ifdef OTTER_TIMER_OVF_CNT_EN
        wreg(32'h4, 0);
        wreg(32'h0, 3);
        idle(1100);
        rdc(BASE + 16, "ovf_saturate", 255);
        wreg(32'h10, 0);
        rd(BASE + 16, "ovf_clear");
        idle(4);
        rd(BASE + 16, "ovf_after");
`else
        wreg(32'h10, 32'hFF);
        rdc(BASE + 16, "ovf_absent", 0);
`endif

        // Randomized traffic against the model
        wreg(32'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65) begin
                idle(1);
            end else begin
                off = 32'($urandom_range(0, 7));
                case (off)
                    32'd0:   d = 32'($urandom_range(0, 7));
                    32'd1:   d = 32'($urandom_range(0, 6));
                    32'd2:   d = 32'($urandom_range(0, 8));
                    default: d = $urandom;
                endcase
                a = BASE + (off << 2) + 32'($urandom_range(0, 3));
                if (r >= 95) a = a + 32'h20;
                else if (r >= 92) a = a - 32'h20;
                cyc(1'b1, a, d);
            end
            rd(BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)), "rand_rd");
        end

        // Asynchronous reset mid-run with EXP set and COUNT=7
        wreg(32'h4, 0);
        wreg(32'h0, 7);
        wait_intr(40, n);
        check("pre_reset_intr", 32'(intr), 1);
        wreg(32'h4, 7);
        wreg(32'h8, 7);
        rdc(BASE + 8, "pre_reset_count", 7);
        #2;
        RST = 1'b0;
        model_reset();
        #1;
        check("async_reset_intr", 32'(intr), 0);
        for (int unsigned k = 0; k < 5; k++) rdc(BASE + 32'(4 * k), "async_reset_reg", '0);
        @(negedge clk);
        RST = 1'b1;
        idle(3);
        rd_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
